// File: rtl/lfsr_word_server_pkg.sv
// Shared definitions for the LFSR word server: LFSR geometry, default seed and
// controller state encoding.
package lfsr_word_server_pkg;

    localparam int unsigned LfsrW = 23;
    localparam int unsigned TapLo = 4;
    localparam int unsigned TapHi = 22;

    localparam logic [LfsrW-1:0] DefaultSeed = 23'd4790770;

    typedef enum logic [1:0] {
        StReseed = 2'd0,
        StFill   = 2'd1,
        StReady  = 2'd2
    } state_e;

endpackage

// File: rtl/lfsr_word_server_if.sv
// Requester/config bus of the LFSR word server.
//   seed     : new LFSR seed (config side)
//   seed_wr  : one-cycle seed write strobe, zero seed ignored
//   req      : level request per requester, held until granted
//   gnt      : registered one-hot grant, one cycle
//   word     : registered random word, valid with word_vld
//   word_vld : high in the grant cycle
//   busy     : no word buffered (reseeding or filling)
// master = consumer/config side, slave = server side.
interface lfsr_word_server_if
    import lfsr_word_server_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned WORD_W = 16
);
    logic [LfsrW-1:0]  seed;
    logic              seed_wr;
    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  gnt;
    logic [WORD_W-1:0] word;
    logic              word_vld;
    logic              busy;

    modport master (
        output seed, seed_wr, req,
        input  gnt, word, word_vld, busy
    );

    modport slave (
        input  seed, seed_wr, req,
        output gnt, word, word_vld, busy
    );
endinterface

// File: rtl/lfsr_23_4_22.sv
// Free-running 23-bit maximal-length Fibonacci LFSR with taps at bits 4 and 22.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset (loads the default seed)
//   seed_i    : value loaded on seed_wr_i
//   seed_wr_i : load strobe; otherwise the register shifts every cycle
//   y_o       : current output bit, sr[4]^sr[22]
module lfsr_23_4_22
    import lfsr_word_server_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [LfsrW-1:0] seed_i,
    input  logic             seed_wr_i,
    output logic             y_o
);

    logic [LfsrW-1:0] sr_q;

    assign y_o = sr_q[TapLo] ^ sr_q[TapHi];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q <= DefaultSeed;
        end else if (seed_wr_i) begin
            sr_q <= seed_i;
        end else begin
            sr_q <= {sr_q[LfsrW-2:0], y_o};
        end
    end

endmodule

// File: rtl/lfsr_word_server.sv
// LFSR word server: owns the PRBS seed, packs the serial PRBS bit into WORD_W-bit
// words (first bit in the MSB) and hands each word to one of N_REQ requesters
// with a round-robin grant.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : lfsr_word_server_if slave (seed/seed_wr/req in, gnt/word/word_vld/busy out)
module lfsr_word_server
    import lfsr_word_server_pkg::*;
#(
    parameter int unsigned      N_REQ       = 4,
    parameter int unsigned      WORD_W      = 16,
    parameter logic [LfsrW-1:0] P_INIT_SEED = DefaultSeed
) (
    input logic                clk,
    input logic                rst,
    lfsr_word_server_if.slave  bus
);

    localparam int unsigned CntW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int unsigned PtrW = $clog2(N_REQ);

    state_e            state_q, state_d;
    logic [CntW-1:0]   fill_cnt_q, fill_cnt_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              vld_q, vld_d;
    logic [PtrW-1:0]   rr_q, rr_d;
    logic [LfsrW-1:0]  seed_q;
    logic              seed_ok;
    logic              lfsr_ld;
    logic              lfsr_y;
    logic [PtrW-1:0]   win;

    // Lowest index at or after ptr (wrapping) with a request; only used when |r.
    function automatic logic [PtrW-1:0] rr_pick(logic [N_REQ-1:0] r, logic [PtrW-1:0] ptr);
        logic [PtrW-1:0] w;
        logic            found;
        int unsigned     idx;
        w     = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(ptr) + k) % N_REQ;
            if (!found && r[PtrW'(idx)]) begin
                w     = PtrW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign seed_ok = bus.seed_wr && (bus.seed != '0);
    assign win     = rr_pick(bus.req, rr_q);

    lfsr_23_4_22 u_lfsr (
        .clk_i     (clk),
        .rst_i     (rst),
        .seed_i    (seed_q),
        .seed_wr_i (lfsr_ld),
        .y_o       (lfsr_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            seed_q <= P_INIT_SEED;
        end else if (seed_ok) begin
            seed_q <= bus.seed;
        end
    end

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        buf_d      = buf_q;
        word_d     = word_q;
        gnt_d      = '0;
        vld_d      = 1'b0;
        rr_d       = rr_q;
        lfsr_ld    = 1'b0;

        // A valid seed write overrides everything, including a pending grant.
        if (seed_ok) begin
            state_d = StReseed;
        end else begin
            unique case (state_q)
                StReseed: begin
                    lfsr_ld    = 1'b1;
                    fill_cnt_d = '0;
                    state_d    = StFill;
                end
                StFill: begin
                    buf_d = (buf_q << 1) | WORD_W'(lfsr_y);
                    if (fill_cnt_q == CntW'(WORD_W - 1)) begin
                        state_d = StReady;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 1'b1;
                    end
                end
                StReady: begin
                    if (|bus.req) begin
                        gnt_d[win] = 1'b1;
                        word_d     = buf_q;
                        vld_d      = 1'b1;
                        rr_d       = (win == PtrW'(N_REQ - 1)) ? '0 : win + 1'b1;
                        fill_cnt_d = '0;
                        state_d    = StFill;
                    end
                end
                default: state_d = StReseed;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StReseed;
            fill_cnt_q <= '0;
            buf_q      <= '0;
            word_q     <= '0;
            gnt_q      <= '0;
            vld_q      <= 1'b0;
            rr_q       <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            buf_q      <= buf_d;
            word_q     <= word_d;
            gnt_q      <= gnt_d;
            vld_q      <= vld_d;
            rr_q       <= rr_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.word     = word_q;
    assign bus.word_vld = vld_q;
    assign bus.busy     = (state_q != StReady);

endmodule
